// File: rtl/ahb_master_skid_fifo.sv
// Elastic skid FIFO between AHB master pipeline stages.
// DEPTH entries, registered upstream stall, optional empty-FIFO bypass (FWFT),
// flush, occupancy, almost-full and sticky protocol-error flag.
module ahb_master_skid_fifo #(
  parameter int unsigned WDT       = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FWFT      = 1,
  parameter int unsigned AF_THRESH = DEPTH - 1
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [WDT-1:0]             i_data,
  output logic                       o_stall,
  output logic                       o_valid,
  output logic [WDT-1:0]             o_data,
  input  logic                       i_stall,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full,
  output logic                       o_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WDT-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic           r_stall;
  logic           r_af;
  logic           r_err;

  logic           w_empty;
  logic           w_acc;
  logic           w_valid;
  logic [WDT-1:0] w_data;
  logic           w_bypass_take;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count_next;

  // Output source selection, push/pop qualification and next occupancy.
  // A bypassed beat stalled downstream is written to storage so it is
  // re-presented unchanged from mem[rd_ptr] on the following cycle.
  always_comb begin
    w_empty       = (r_count == '0);
    w_acc         = i_valid & ~r_stall & ~i_flush;
    w_valid       = 1'b0;
    w_data        = '0;
    if (!w_empty) begin
      w_valid = 1'b1;
      w_data  = r_mem[r_rd_ptr];
    end else if (FWFT != 0) begin
      w_valid = w_acc;
      w_data  = i_data;
    end
    if (!i_resetn || i_flush) begin
      w_valid = 1'b0;
    end
    w_bypass_take = (FWFT != 0) & w_empty & w_acc & ~i_stall;
    w_push        = w_acc & ~w_bypass_take;
    w_pop         = ~w_empty & ~i_stall & ~i_flush;
    if (i_flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Control state: pointers, occupancy, registered stall/almost-full, error.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_stall  <= 1'b0;
      r_af     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err   <= r_err | (i_valid & r_stall);
      r_count <= w_count_next;
      r_stall <= (w_count_next == CW'(DEPTH));
      r_af    <= (w_count_next >= CW'(AF_THRESH));
      if (i_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_resetn && w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_valid       = w_valid;
  assign o_data        = w_valid ? w_data : '0;
  assign o_stall       = r_stall;
  assign o_count       = r_count;
  assign o_almost_full = r_af;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ahb_master_skid_fifo.sv
// Scoreboard bench: DUT A (FWFT=1) runs directed scenarios, DUT B (FWFT=0)
// runs a long random stream against a small occupancy model.
module tb_ahb_master_skid_fifo;

  localparam int unsigned WDT   = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] qa [$];
  logic [31:0] qb [$];

  // DUT A signals
  logic           a_iresetn, a_iflush, a_ivalid, a_istall;
  logic [WDT-1:0] a_idata, a_odata;
  logic           a_ostall, a_ovalid, a_oaf, a_oerr;
  logic [CW-1:0]  a_ocount;

  // DUT B signals
  logic           b_iresetn, b_iflush, b_ivalid, b_istall;
  logic [WDT-1:0] b_idata, b_odata;
  logic           b_ostall, b_ovalid, b_oaf, b_oerr;
  logic [CW-1:0]  b_ocount;

  ahb_master_skid_fifo #(
    .WDT(WDT), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(DEPTH - 1)
  ) u_dut_a (
    .i_clk(clk), .i_resetn(a_iresetn), .i_flush(a_iflush),
    .i_valid(a_ivalid), .i_data(a_idata), .o_stall(a_ostall),
    .o_valid(a_ovalid), .o_data(a_odata), .i_stall(a_istall),
    .o_count(a_ocount), .o_almost_full(a_oaf), .o_err(a_oerr)
  );

  ahb_master_skid_fifo #(
    .WDT(WDT), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(DEPTH - 1)
  ) u_dut_b (
    .i_clk(clk), .i_resetn(b_iresetn), .i_flush(b_iflush),
    .i_valid(b_ivalid), .i_data(b_idata), .o_stall(b_ostall),
    .o_valid(b_ovalid), .o_data(b_odata), .i_stall(b_istall),
    .o_count(b_ocount), .o_almost_full(b_oaf), .o_err(b_oerr)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor A: every downstream transfer must match the head of the queue.
  always @(negedge clk) begin
    if (a_ovalid && !a_istall) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_beat: got 0x%0h expected no beat", a_odata);
      end else begin
        chk("a_order", a_odata, qa.pop_front());
      end
    end else if (!a_ovalid) begin
      chk("a_zero_data", a_odata, 32'h0);
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (b_ovalid && !b_istall) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_beat: got 0x%0h expected no beat", b_odata);
      end else begin
        chk("b_order", b_odata, qb.pop_front());
      end
    end else if (!b_ovalid) begin
      chk("b_zero_data", b_odata, 32'h0);
    end
  end

  task automatic run_a();
    a_iresetn = 1'b0; a_iflush = 1'b0; a_ivalid = 1'b1;
    a_idata = 32'hDEAD_BEEF; a_istall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_valid", a_ovalid, 0);
    chk("a_rst_count", a_ocount, 0);
    chk("a_rst_stall", a_ostall, 0);
    chk("a_rst_af", a_oaf, 0);
    chk("a_rst_err", a_oerr, 0);
    a_iresetn = 1'b1; a_ivalid = 1'b0;
    @(posedge clk); #1;

    // Zero-latency bypass into an empty FIFO.
    a_ivalid = 1'b1; a_idata = 32'hA5A5_0001; qa.push_back(32'hA5A5_0001);
    @(negedge clk);
    chk("t1_valid", a_ovalid, 1);
    chk("t1_data", a_odata, 32'hA5A5_0001);
    @(posedge clk); #1;
    a_ivalid = 1'b0;
    chk("t1_count", a_ocount, 0);

    // Fill under downstream stall.
    for (int k = 0; k < 4; k++) begin
      a_ivalid = 1'b1; a_idata = 32'h10 + k; a_istall = 1'b1;
      qa.push_back(32'h10 + k);
      @(posedge clk); #1;
      chk("t2_count", a_ocount, k + 1);
      chk("t2_af", a_oaf, (k >= 2));
      chk("t2_stall", a_ostall, (k == 3));
    end
    chk("t2_hold_data", a_odata, 32'h10);

    // Protocol violation while full: beat dropped, error set.
    a_ivalid = 1'b1; a_idata = 32'hEE;
    chk("t4_stall_pre", a_ostall, 1);
    @(posedge clk); #1;
    chk("t4_count", a_ocount, 4);
    chk("t4_err", a_oerr, 1);
    chk("t2_hold_data2", a_odata, 32'h10);

    // Single pop at full, then a post-full push.
    a_ivalid = 1'b0; a_istall = 1'b0;
    @(posedge clk); #1;
    chk("t3_count", a_ocount, 3);
    chk("t3_stall", a_ostall, 0);
    a_istall = 1'b1; a_ivalid = 1'b1; a_idata = 32'h14; qa.push_back(32'h14);
    @(posedge clk); #1;
    a_ivalid = 1'b0;
    chk("t3_count_full", a_ocount, 4);
    chk("t3_stall_full", a_ostall, 1);
    a_istall = 1'b0;
    for (int i = 0; i < 10 && qa.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("t3_drained", qa.size(), 0);
    @(posedge clk); #1;
    chk("t3_count_empty", a_ocount, 0);
    chk("t4_err_sticky", a_oerr, 1);

    // Flush with three beats stored and a beat arriving.
    a_istall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_ivalid = 1'b1; a_idata = 32'h20 + k; qa.push_back(32'h20 + k);
      @(posedge clk); #1;
    end
    chk("t5_count3", a_ocount, 3);
    chk("t5_af", a_oaf, 1);
    a_iflush = 1'b1; a_ivalid = 1'b1; a_idata = 32'h99; a_istall = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("t5_flush_valid", a_ovalid, 0);
    @(posedge clk); #1;
    a_iflush = 1'b0;
    chk("t5_count", a_ocount, 0);
    chk("t5_stall", a_ostall, 0);
    chk("t5_af0", a_oaf, 0);
    chk("t5_err_kept", a_oerr, 1);
    a_ivalid = 1'b1; a_idata = 32'h30; qa.push_back(32'h30);
    @(negedge clk);
    chk("t5_fwft_follow", a_ovalid, 1);
    @(posedge clk); #1;
    a_ivalid = 1'b0;
    chk("t5_count_after", a_ocount, 0);
    @(negedge clk);
    chk("t5_idle_valid", a_ovalid, 0);

    // Only reset clears the error flag.
    @(posedge clk); #1;
    a_iresetn = 1'b0;
    @(posedge clk); #1;
    a_iresetn = 1'b1;
    chk("t4_err_reset", a_oerr, 0);
    chk("a_queue_empty", qa.size(), 0);
  endtask

  task automatic run_b();
    int  m_cnt  = 0;
    bit  m_stall = 1'b0;
    bit  m_af    = 1'b0;
    bit  m_err   = 1'b0;
    bit  v, s, f, r, acc, pop;
    logic [31:0] d;
    b_iresetn = 1'b0; b_iflush = 1'b0; b_ivalid = 1'b0;
    b_idata = '0; b_istall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b_iresetn = 1'b1;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      @(posedge clk); #1;
      chk("b_count", b_ocount, m_cnt);
      chk("b_count_bound", (b_ocount <= DEPTH), 1);
      chk("b_stall", b_ostall, m_stall);
      chk("b_af", b_oaf, m_af);
      chk("b_err", b_oerr, m_err);
      chk("b_valid", b_ovalid, (m_cnt != 0));

      r = !(cyc >= 5000 && cyc < 5002);
      v = (cyc < 10000) && ($urandom_range(0, 99) < 55);
      s = (cyc < 10000) && ($urandom_range(0, 99) < 45);
      f = (cyc < 10000) && r && ($urandom_range(0, 999) < 5);
      d = $urandom;
      b_iresetn = r; b_ivalid = v; b_istall = s; b_iflush = f; b_idata = d;

      if (!r) begin
        m_cnt = 0; m_err = 1'b0;
        qb.delete();
      end else begin
        acc = v && !m_stall && !f;
        m_err = m_err | (v & m_stall);
        if (f) begin
          m_cnt = 0;
          qb.delete();
        end else begin
          pop = (m_cnt != 0) && !s;
          if (acc) qb.push_back(d);
          m_cnt = m_cnt + int'(acc) - int'(pop);
        end
      end
      m_stall = (m_cnt == DEPTH);
      m_af    = (m_cnt >= DEPTH - 1);
    end
    chk("b_drained", qb.size(), 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog timeout");
  end

endmodule
